// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the LVDS PLL, clocked by the PLL reference clock.
// Optional lock-loss event counter output enabled by `define PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       lvds_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [2:0] retry_cnt_o
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt_o
`endif
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    retry_d;
  logic          sync1, lk;

  // Counter counts cycles spent in the current state; cleared on every entry.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    retry_d = retry_cnt_o;
    if (restart_i) begin
      state_d = RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state)
        RST_PLL: begin
          if (cnt == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d = QUALIFY;
            cnt_d   = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_d = '0;
            if (retry_cnt_o == RETRY_MAX) begin
              state_d = FAIL;
            end else begin
              state_d = RST_PLL;
              retry_d = retry_cnt_o + 3'd1;
            end
          end
        end
        QUALIFY: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!lk) state_d = RST_PLL;
        end
        FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = RST_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= 1'b0;
      lk           <= 1'b0;
      state        <= RST_PLL;
      cnt          <= '0;
      retry_cnt_o  <= '0;
      pll_rst_o    <= 1'b1;
      lvds_rst_n_o <= 1'b0;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      sync1        <= pll_locked_i;
      lk           <= sync1;
      state        <= state_d;
      cnt          <= cnt_d;
      retry_cnt_o  <= retry_d;
      pll_rst_o    <= (state_d == RST_PLL) || (state_d == FAIL);
      lvds_rst_n_o <= (state_d == RUN);
      ready_o      <= (state_d == RUN);
      fail_o       <= (state_d == FAIL);
    end
  end

  assign state_o = state;

`ifdef PLL_SEQ_LOSS_CNT_EN
  // Lock-loss events survive restart_i; only rst_n clears them.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_o <= '0;
    end else if (!restart_i && (state == RUN) && !lk && (loss_cnt_o != 8'hFF)) begin
      loss_cnt_o <= loss_cnt_o + 8'd1;
    end
  end
`endif

endmodule
